// File: rtl/core_pkg.sv
// Shared types for the memory port arbiter: FSM states and requester identities.
package core_pkg;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned DATA_W_DEF = 32;

   typedef enum logic [1:0] {ARB_IDLE, ARB_RD, ARB_WR, ARB_DONE} arb_state_t;
   typedef enum logic {REQ_IF, REQ_LS} req_id_t;

   function automatic req_id_t other_req(input req_id_t r);
      return (r == REQ_IF) ? REQ_LS : REQ_IF;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input arbiter between fetch and load/store; remembers the last grant for
// round-robin on ties, or lets LS win every tie when FAIR is 0.
module rr_arb2
   import core_pkg::*;
#(
   parameter bit FAIR = 1'b1
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    req_if,
   input  logic    req_ls,
   input  logic    gnt_en,
   output req_id_t gnt_c,
   output logic    any_c
);

   req_id_t last_gnt;

   assign any_c = req_if | req_ls;

   always_comb begin
      gnt_c = REQ_IF;
      if (req_if && req_ls) begin
         gnt_c = FAIR ? other_req(last_gnt) : REQ_LS;
      end else if (req_ls) begin
         gnt_c = REQ_LS;
      end
   end

   // Reset to IF so that LS wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_gnt <= REQ_IF;
      end else if (gnt_en && any_c) begin
         last_gnt <= gnt_c;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, sequencing
// the rready/rvalid and wvalid/wready handshakes with registered outputs.
module mem_port_arbiter
   import core_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter bit          FAIR   = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_done,
   output logic [DATA_W-1:0] ls_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              rready,
   input  logic              rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              wvalid,
   input  logic              wready
);

   arb_state_t        state, state_nxt;
   req_id_t           owner, owner_nxt;
   req_id_t           gnt_c;
   logic              any_c;
   logic              gnt_en_c;
   logic              rready_nxt, wvalid_nxt, if_done_nxt, ls_done_nxt;
   logic [ADDR_W-1:0] mem_addr_nxt;
   logic [DATA_W-1:0] mem_wdata_nxt, if_rdata_nxt, ls_rdata_nxt;

   assign gnt_en_c = (state == ARB_IDLE);

   rr_arb2 #(.FAIR(FAIR)) u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req_if (if_req),
      .req_ls (ls_req),
      .gnt_en (gnt_en_c),
      .gnt_c  (gnt_c),
      .any_c  (any_c)
   );

   // Next state and next registered outputs; done pulses default low.
   always_comb begin
      state_nxt     = state;
      owner_nxt     = owner;
      rready_nxt    = rready;
      wvalid_nxt    = wvalid;
      if_done_nxt   = 1'b0;
      ls_done_nxt   = 1'b0;
      mem_addr_nxt  = mem_addr;
      mem_wdata_nxt = mem_wdata;
      if_rdata_nxt  = if_rdata;
      ls_rdata_nxt  = ls_rdata;
      case (state)
         ARB_IDLE: begin
            if (any_c) begin
               owner_nxt = gnt_c;
               if (gnt_c == REQ_LS) begin
                  mem_addr_nxt = ls_addr;
                  if (ls_we) begin
                     mem_wdata_nxt = ls_wdata;
                     wvalid_nxt    = 1'b1;
                     state_nxt     = ARB_WR;
                  end else begin
                     rready_nxt = 1'b1;
                     state_nxt  = ARB_RD;
                  end
               end else begin
                  mem_addr_nxt = if_addr;
                  rready_nxt   = 1'b1;
                  state_nxt    = ARB_RD;
               end
            end
         end
         ARB_RD: begin
            if (rvalid) begin
               rready_nxt = 1'b0;
               state_nxt  = ARB_DONE;
               if (owner == REQ_IF) begin
                  if_rdata_nxt = mem_rdata;
                  if_done_nxt  = 1'b1;
               end else begin
                  ls_rdata_nxt = mem_rdata;
                  ls_done_nxt  = 1'b1;
               end
            end
         end
         ARB_WR: begin
            if (wready) begin
               wvalid_nxt  = 1'b0;
               ls_done_nxt = 1'b1;
               state_nxt   = ARB_DONE;
            end
         end
         // One bubble: a requester still holding req during done is not re-granted.
         ARB_DONE: state_nxt = ARB_IDLE;
         default:  state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ARB_IDLE;
         owner     <= REQ_IF;
         rready    <= 1'b0;
         wvalid    <= 1'b0;
         if_done   <= 1'b0;
         ls_done   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         ls_rdata  <= '0;
      end else begin
         state     <= state_nxt;
         owner     <= owner_nxt;
         rready    <= rready_nxt;
         wvalid    <= wvalid_nxt;
         if_done   <= if_done_nxt;
         ls_done   <= ls_done_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_wdata <= mem_wdata_nxt;
         if_rdata  <= if_rdata_nxt;
         ls_rdata  <= ls_rdata_nxt;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model of the port.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, ls_req, ls_we, rvalid, wready;
   logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;

   logic        f_if_done, f_ls_done, f_rready, f_wvalid;
   logic [31:0] f_if_rdata, f_ls_rdata, f_mem_addr, f_mem_wdata;
   logic        p_if_done, p_ls_done, p_rready, p_wvalid;
   logic [31:0] p_if_rdata, p_ls_rdata, p_mem_addr, p_mem_wdata;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .FAIR(1'b1)) u_fair (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_done(f_if_done), .if_rdata(f_if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_done(f_ls_done), .ls_rdata(f_ls_rdata),
      .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
      .rready(f_rready), .rvalid(rvalid), .mem_rdata(mem_rdata),
      .wvalid(f_wvalid), .wready(wready)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .FAIR(1'b0)) u_prio (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_done(p_if_done), .if_rdata(p_if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_done(p_ls_done), .ls_rdata(p_ls_rdata),
      .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata),
      .rready(p_rready), .rvalid(rvalid), .mem_rdata(mem_rdata),
      .wvalid(p_wvalid), .wready(wready)
   );

   int vectors = 0;
   int miscompares = 0;

   // Model of the FAIR=1 port: what transaction is in flight and what each output must be.
   // m_busy: 0 free, 1 waiting for read data, 2 waiting for write accept, 3 completing.
   int          m_busy;
   bit          m_owner_ls, m_last_ls;
   logic [31:0] e_rready, e_wvalid, e_if_done, e_ls_done;
   logic [31:0] e_mem_addr, e_mem_wdata, e_if_rdata, e_ls_rdata;

   int f_order[$];
   int p_ls_cnt, p_if_cnt;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_owner_ls = 1'b0; m_last_ls = 1'b0;
      e_rready = 0; e_wvalid = 0; e_if_done = 0; e_ls_done = 0;
      e_mem_addr = 0; e_mem_wdata = 0; e_if_rdata = 0; e_ls_rdata = 0;
   endtask

   task automatic model_edge();
      bit pick_ls;
      if (m_busy == 3) begin
         e_if_done = 0; e_ls_done = 0; m_busy = 0;
      end else if (m_busy == 0) begin
         if (if_req || ls_req) begin
            pick_ls = (if_req && ls_req) ? !m_last_ls : ls_req;
            m_last_ls = pick_ls; m_owner_ls = pick_ls;
            e_mem_addr = pick_ls ? ls_addr : if_addr;
            if (pick_ls && ls_we) begin
               e_mem_wdata = ls_wdata; e_wvalid = 1; m_busy = 2;
            end else begin
               e_rready = 1; m_busy = 1;
            end
         end
      end else if (m_busy == 1) begin
         if (rvalid) begin
            e_rready = 0; m_busy = 3;
            if (m_owner_ls) begin e_ls_rdata = mem_rdata; e_ls_done = 1; end
            else begin e_if_rdata = mem_rdata; e_if_done = 1; end
         end
      end else if (wready) begin
         e_wvalid = 0; e_ls_done = 1; m_busy = 3;
      end
   endtask

   task automatic compare_all();
      check("rready",    32'(f_rready),  e_rready);
      check("wvalid",    32'(f_wvalid),  e_wvalid);
      check("if_done",   32'(f_if_done), e_if_done);
      check("ls_done",   32'(f_ls_done), e_ls_done);
      check("mem_addr",  f_mem_addr,     e_mem_addr);
      check("mem_wdata", f_mem_wdata,    e_mem_wdata);
      check("if_rdata",  f_if_rdata,     e_if_rdata);
      check("ls_rdata",  f_ls_rdata,     e_ls_rdata);
      if (f_rready && f_wvalid) check("rready_wvalid_excl", 32'd1, 32'd0);
      if (f_if_done && f_ls_done) check("done_excl", 32'd1, 32'd0);
   endtask

   // One clock: model consumes pre-edge inputs, then outputs are compared 1ns later.
   task automatic tick();
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
      compare_all();
      if (f_ls_done) f_order.push_back(1);
      if (f_if_done) f_order.push_back(0);
      p_ls_cnt += 32'(p_ls_done);
      p_if_cnt += 32'(p_if_done);
   endtask

   task automatic idle_inputs();
      if_req = 0; ls_req = 0; ls_we = 0; rvalid = 0; wready = 0;
      if_addr = 0; ls_addr = 0; ls_wdata = 0; mem_rdata = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      compare_all();
   endtask

   initial begin
      int wv_cnt, ls_cnt, if_cnt;
      int exp_ord[4];
      bit if_rel, ls_rel;
      exp_ord = '{1, 0, 1, 0};

      do_reset();
      check("reset_rready", 32'(f_rready), 32'd0);
      check("reset_prio_rready", 32'(p_rready), 32'd0);

      // IF read, memory answers in the first rready cycle.
      if_req = 1; if_addr = 32'h100;
      tick();
      check("t1_rready", 32'(f_rready), 32'd1);
      check("t1_addr", f_mem_addr, 32'h100);
      rvalid = 1; mem_rdata = 32'hDEADBEEF;
      tick();
      check("t1_done", 32'(f_if_done), 32'd1);
      check("t1_rdata", f_if_rdata, 32'hDEADBEEF);
      if_req = 0; rvalid = 0; mem_rdata = 0;
      tick();
      check("t1_done_pulse", 32'(f_if_done), 32'd0);

      // Spurious rvalid while idle must not disturb anything.
      rvalid = 1; mem_rdata = 32'h0BAD0BAD;
      repeat (3) tick();
      rvalid = 0;
      check("spur_idle_rdata", f_if_rdata, 32'hDEADBEEF);

      // LS store with wready delayed 4 cycles, spurious rvalid during WR.
      ls_req = 1; ls_we = 1; ls_addr = 32'h200; ls_wdata = 32'h12345678;
      wv_cnt = 0; ls_cnt = 0; if_cnt = 0;
      for (int k = 1; k <= 9; k++) begin
         tick();
         wv_cnt += 32'(f_wvalid); ls_cnt += 32'(f_ls_done); if_cnt += 32'(f_if_done);
         if (f_ls_done) ls_req = 0;
         wready = (k == 5);
         rvalid = (k == 2 || k == 3);
         mem_rdata = 32'h55AA55AA;
      end
      rvalid = 0; wready = 0;
      check("t2_wvalid_cycles", 32'(wv_cnt), 32'd5);
      check("t2_ls_done_cnt", 32'(ls_cnt), 32'd1);
      check("t2_if_done_cnt", 32'(if_cnt), 32'd0);
      check("t2_wdata", f_mem_wdata, 32'h12345678);
      check("t2_spur_ls_rdata", f_ls_rdata, 32'h0);
      check("t2_spur_if_rdata", f_if_rdata, 32'hDEADBEEF);

      // Both requesters held for 4 transactions from reset.
      do_reset();
      f_order.delete(); p_ls_cnt = 0; p_if_cnt = 0;
      if_req = 1; ls_req = 1; ls_we = 0; if_addr = 32'h10; ls_addr = 32'h20;
      rvalid = 1; mem_rdata = 32'h77;
      repeat (12) tick();
      check("t3_order_len", 32'(f_order.size()), 32'd4);
      for (int i = 0; i < 4 && i < f_order.size(); i++)
         check("t3_order", 32'(f_order[i]), 32'(exp_ord[i]));
      check("t3_prio_ls", 32'(p_ls_cnt), 32'd4);
      check("t3_prio_if", 32'(p_if_cnt), 32'd0);
      if_req = 0; ls_req = 0; rvalid = 0;
      repeat (3) tick();

      // LS load whose address changes while the read is outstanding.
      ls_req = 1; ls_we = 0; ls_addr = 32'h300;
      tick();
      check("t4_addr_grant", f_mem_addr, 32'h300);
      ls_addr = 32'h400;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("t4_addr_hold", f_mem_addr, 32'h300);
      end
      rvalid = 1; mem_rdata = 32'hCAFEF00D;
      tick();
      check("t4_done", 32'(f_ls_done), 32'd1);
      check("t4_rdata", f_ls_rdata, 32'hCAFEF00D);
      check("t4_addr_done", f_mem_addr, 32'h300);
      ls_req = 0; rvalid = 0;
      tick();

      // Asynchronous reset in the middle of a write.
      ls_req = 1; ls_we = 1; ls_addr = 32'h500; ls_wdata = 32'hA5A5A5A5;
      repeat (2) tick();
      check("t5_wvalid_before", 32'(f_wvalid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_wvalid_async", 32'(f_wvalid), 32'd0);
      check("t5_addr_async", f_mem_addr, 32'h0);
      check("t5_ifrd_async", f_if_rdata, 32'h0);
      model_reset();
      idle_inputs();
      @(negedge clk) rst_n = 1'b1;
      tick();
      check("t5_after_wvalid", 32'(f_wvalid), 32'd0);
      check("t5_after_wdata", f_mem_wdata, 32'h0);

      // Random traffic with a randomly slow memory.
      if_rel = 0; ls_rel = 0;
      for (int c = 0; c < 3000; c++) begin
         tick();
         rvalid = ($urandom % 3 == 0);
         wready = ($urandom % 3 == 0);
         mem_rdata = $urandom;
         if (if_rel) begin
            if_rel = 0;
            if ($urandom % 2 == 0) if_req = 0;
            else if_addr = $urandom;
         end else if (f_if_done) begin
            if_rel = 1;
         end else if (!if_req && $urandom % 4 == 0) begin
            if_req = 1; if_addr = $urandom;
         end
         if (ls_rel) begin
            ls_rel = 0;
            if ($urandom % 2 == 0) ls_req = 0;
            else begin ls_addr = $urandom; ls_wdata = $urandom; ls_we = 1'($urandom % 2); end
         end else if (f_ls_done) begin
            ls_rel = 1;
         end else if (!ls_req && $urandom % 4 == 0) begin
            ls_req = 1; ls_addr = $urandom; ls_wdata = $urandom; ls_we = 1'($urandom % 2);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
